// File: rtl/clos_alloc.sv
// Path allocator for the 5-port Clos switch: round-robin request selection, CM search and release.
// Optional statistics outputs (blk, blk_cnt) are enabled by defining CLOS_ALLOC_STAT_EN.
module clos_alloc #(
    parameter int MN = 2,
    parameter int NN = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [4:0][NN-1:0]         req,
    input  logic [4:0][NN-1:0][2:0]    req_dir,
    output logic [4:0][NN-1:0]         gnt,
    output logic [4:0][NN-1:0]         nack,
    input  logic [4:0][NN-1:0]         rel,
    output logic [4:0][MN-1:0][NN-1:0] imcfg,
    output logic [MN-1:0][1:0]         scfg,
    output logic [MN-1:0][1:0]         ncfg,
    output logic [MN-1:0][3:0]         wcfg,
    output logic [MN-1:0][3:0]         ecfg,
    output logic [MN-1:0][3:0]         lcfg
`ifdef CLOS_ALLOC_STAT_EN
    ,
    output logic [15:0]                blk_cnt,
    output logic                       blk
`endif
);
    localparam int NF  = 5 * NN;
    localparam int PW  = $clog2(NF);
    localparam int CMW = (MN > 1) ? $clog2(MN) : 1;
    localparam int VW  = (NN > 1) ? $clog2(NN) : 1;

    typedef enum logic {IDLE, SRCH} state_e;

    typedef struct packed {
        logic       legal;
        logic [3:0] pos;
    } cfg_pos_t;

    // Each CM keeps one 16-bit word: S[1:0], W[5:2], N[7:6], E[11:8], L[15:12].
    function automatic cfg_pos_t cfg_pos(input logic [2:0] src, input logic [2:0] dst);
        cfg_pos = '0;
        case (dst)
            3'd0: case (src) 3'd2: cfg_pos = {1'b1, 4'd0};  3'd4: cfg_pos = {1'b1, 4'd1};
                             default: cfg_pos = '0; endcase
            3'd1: case (src) 3'd0: cfg_pos = {1'b1, 4'd2};  3'd2: cfg_pos = {1'b1, 4'd3};
                             3'd3: cfg_pos = {1'b1, 4'd4};  3'd4: cfg_pos = {1'b1, 4'd5};
                             default: cfg_pos = '0; endcase
            3'd2: case (src) 3'd0: cfg_pos = {1'b1, 4'd6};  3'd4: cfg_pos = {1'b1, 4'd7};
                             default: cfg_pos = '0; endcase
            3'd3: case (src) 3'd0: cfg_pos = {1'b1, 4'd8};  3'd1: cfg_pos = {1'b1, 4'd9};
                             3'd2: cfg_pos = {1'b1, 4'd10}; 3'd4: cfg_pos = {1'b1, 4'd11};
                             default: cfg_pos = '0; endcase
            3'd4: case (src) 3'd0: cfg_pos = {1'b1, 4'd12}; 3'd1: cfg_pos = {1'b1, 4'd13};
                             3'd2: cfg_pos = {1'b1, 4'd14}; 3'd3: cfg_pos = {1'b1, 4'd15};
                             default: cfg_pos = '0; endcase
            default: cfg_pos = '0;
        endcase
    endfunction

    function automatic logic [15:0] dst_mask(input logic [2:0] dst);
        case (dst)
            3'd0:    dst_mask = 16'h0003;
            3'd1:    dst_mask = 16'h003C;
            3'd2:    dst_mask = 16'h00C0;
            3'd3:    dst_mask = 16'h0F00;
            3'd4:    dst_mask = 16'hF000;
            default: dst_mask = 16'h0000;
        endcase
    endfunction

    logic [NF-1:0]              req_f, rel_f;
    logic [NF-1:0][2:0]         dir_f;

    state_e                     state_q, state_d;
    logic [PW-1:0]              ptr_q, ptr_d, sel_q, sel_d;
    logic [2:0]                 sel_p_q, sel_p_d, sel_dir_q, sel_dir_d;
    logic [VW-1:0]              sel_v_q, sel_v_d;
    logic [NF-1:0]              alloc_v_q, alloc_v_d;
    logic [NF-1:0][CMW-1:0]     alloc_cm_q, alloc_cm_d;
    logic [NF-1:0][2:0]         alloc_dir_q, alloc_dir_d;
    logic [4:0][MN-1:0][NN-1:0] imcfg_q, imcfg_d;
    logic [MN-1:0][15:0]        cm_q, cm_d;
    logic [NF-1:0]              gnt_q, gnt_d, nack_q, nack_d;

    cfg_pos_t                   sel_pos;
    logic                       found;
    logic [CMW-1:0]             pick;

    assign req_f = req;
    assign rel_f = rel;
    assign dir_f = req_dir;

    // IM and CM occupancy are read straight from the configuration, so they cannot drift apart.
    always_comb begin
        sel_pos = cfg_pos(sel_p_q, sel_dir_q);
        found   = 1'b0;
        pick    = '0;
        for (int m = MN - 1; m >= 0; m--) begin
            if (!(|imcfg_q[sel_p_q][m]) && ((cm_q[m] & dst_mask(sel_dir_q)) == 16'h0000)) begin
                found = 1'b1;
                pick  = CMW'(m);
            end
        end
    end

    always_comb begin
        logic [PW:0]   cand;
        logic [PW-1:0] idx;
        logic          hit;
        cfg_pos_t      rp;
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        state_d     = state_q;
        ptr_d       = ptr_q;
        sel_d       = sel_q;
        sel_p_d     = sel_p_q;
        sel_v_d     = sel_v_q;
        sel_dir_d   = sel_dir_q;
        alloc_v_d   = alloc_v_q;
        alloc_cm_d  = alloc_cm_q;
        alloc_dir_d = alloc_dir_q;
        imcfg_d     = imcfg_q;
        cm_d        = cm_q;
        gnt_d       = '0;
        nack_d      = '0;
        cand        = '0;
        idx         = '0;
        hit         = 1'b0;
        rp          = '0;

        for (int f = 0; f < NF; f++) begin
            if (rel_f[f] && alloc_v_q[f]) begin
                rp = cfg_pos(3'(f / NN), alloc_dir_q[f]);
                imcfg_d[f / NN][alloc_cm_q[f]][f % NN] = 1'b0;
                cm_d[alloc_cm_q[f]][rp.pos]            = 1'b0;
                alloc_v_d[f]                           = 1'b0;
            end
        end

        case (state_q)
            IDLE: begin
                for (int i = 0; i < NF; i++) begin
                    cand = {1'b0, ptr_q} + (PW + 1)'(i);
                    if (cand >= (PW + 1)'(NF)) cand = cand - (PW + 1)'(NF);
                    idx = cand[PW-1:0];
                    if (!hit && req_f[idx] && !alloc_v_q[idx]) begin
                        hit       = 1'b1;
                        sel_d     = idx;
                        sel_p_d   = 3'(int'(idx) / NN);
                        sel_v_d   = VW'(int'(idx) % NN);
                        sel_dir_d = dir_f[idx];
                    end
                end
                if (hit) state_d = SRCH;
            end
            SRCH: begin
                state_d = IDLE;
                ptr_d   = (sel_q == PW'(NF - 1)) ? '0 : sel_q + 1'b1;
                if (req_f[sel_q]) begin
                    if (!sel_pos.legal) begin
                        nack_d[sel_q] = 1'b1;
                    end else if (found) begin
                        imcfg_d[sel_p_q][pick][sel_v_q] = 1'b1;
                        cm_d[pick][sel_pos.pos]         = 1'b1;
                        alloc_v_d[sel_q]                = 1'b1;
                        alloc_cm_d[sel_q]               = pick;
                        alloc_dir_d[sel_q]              = sel_dir_q;
                        gnt_d[sel_q]                    = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: configuration and allocation arrays are plain flops and must all be cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            sel_q       <= '0;
            sel_p_q     <= '0;
            sel_v_q     <= '0;
            sel_dir_q   <= '0;
            alloc_v_q   <= '0;
            alloc_cm_q  <= '0;
            alloc_dir_q <= '0;
            imcfg_q     <= '0;
            cm_q        <= '0;
            gnt_q       <= '0;
            nack_q      <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            sel_q       <= sel_d;
            sel_p_q     <= sel_p_d;
            sel_v_q     <= sel_v_d;
            sel_dir_q   <= sel_dir_d;
            alloc_v_q   <= alloc_v_d;
            alloc_cm_q  <= alloc_cm_d;
            alloc_dir_q <= alloc_dir_d;
            imcfg_q     <= imcfg_d;
            cm_q        <= cm_d;
            gnt_q       <= gnt_d;
            nack_q      <= nack_d;
        end
    end

    assign gnt   = gnt_q;
    assign nack  = nack_q;
    assign imcfg = imcfg_q;

    always_comb begin
        for (int m = 0; m < MN; m++) begin
            scfg[m] = cm_q[m][1:0];
            wcfg[m] = cm_q[m][5:2];
            ncfg[m] = cm_q[m][7:6];
            ecfg[m] = cm_q[m][11:8];
            lcfg[m] = cm_q[m][15:12];
        end
    end

`ifdef CLOS_ALLOC_STAT_EN
    logic        blocked;
    logic        blk_q;
    logic [15:0] blk_cnt_q, blk_cnt_d;

    assign blocked   = (state_q == SRCH) && req_f[sel_q] && sel_pos.legal && !found;
    assign blk_cnt_d = (blocked && (blk_cnt_q != 16'hFFFF)) ? blk_cnt_q + 16'd1 : blk_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blk_q     <= 1'b0;
            blk_cnt_q <= '0;
        end else begin
            blk_q     <= blocked;
            blk_cnt_q <= blk_cnt_d;
        end
    end

    assign blk     = blk_q;
    assign blk_cnt = blk_cnt_q;
`endif

endmodule

// File: doc/clos_alloc.md
Name: clos_alloc

Overview:
- Synchronous path allocator for the 5-port data Clos switch: IMs S/W/N/E/L, MN central modules with XY-restricted crossbars, no OMs.
- Takes per-port, per-virtual-circuit route requests and picks a free central module.
- Drives the IM configuration word and the five per-CM crossbar configuration vectors. Frees paths on release.
- Handles one allocation at a time; requesters are served in round-robin order.

Parameters:
- MN, 2, number of central modules.
- NN, 2, virtual circuits per port (IM width).
- Flat requester index f = port*NN + vc. Ports are numbered 0=S, 1=W, 2=N, 3=E, 4=L.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, active low.
- req  in  5*NN  packed [4:0][NN-1:0]; request pending; held until gnt or nack.
- req_dir  in  5*NN*3  packed [4:0][NN-1:0][2:0]; destination port 0..4; stable while req is high.
- gnt  out  5*NN  one-cycle grant pulse.
- nack  out  5*NN  one-cycle pulse for an illegal request.
- rel  in  5*NN  one-cycle release of an allocated path.
- imcfg  out  5*MN*NN  packed [4:0][MN-1:0][NN-1:0]; bit [p][m][v] connects IM p circuit v to CM m.
- scfg, ncfg  out  MN*2 each  packed [MN-1:0][1:0].
- wcfg, ecfg, lcfg  out  MN*4 each  packed [MN-1:0][3:0].

Behaviour:
- Reset: one clock, synchronous active-low reset (rst_n sampled on the rising edge of clk).
  - All outputs 0; all occupancy and allocation state cleared; state IDLE; ptr=0.
  - Reset asserted mid-search drops the search with no gnt.
- CM configuration bit order (source ports):
  - scfg = {L,N}; ncfg = {L,S}.
  - wcfg = {L,E,N,S}; ecfg = {L,N,W,S}; lcfg = {E,N,W,S}.
  - Bit 0 is the first listed from the right.
- Legal pairs are exactly those above.
  - Illegal: src==dst, Y-to-X turns (W/E to S/N), and dir>4.
- State per requester f: alloc_v[f] and alloc_cm[f] (index width max(1,clog2(MN))), plus alloc_dir[f].
- Occupancy: im_busy[p][m], cm_busy[m][d].
- Pending is defined as req[f] & ~alloc_v[f].
- FSM:
  - IDLE: if any pending, select the first pending f at or after ptr, wrapping; latch f and dir; go SRCH. Otherwise stay in IDLE.
  - SRCH:
    - If req[f] has dropped: abort to IDLE, no pulse.
    - Else if the pair is illegal: nack[f]=1 for this cycle, ptr=f+1 mod 5*NN, go IDLE.
    - Else choose the lowest m with !im_busy[p][m] && !cm_busy[m][d].
      - If found, registered on this edge: imcfg[p][m][v]=1, the matching CM cfg bit =1, im_busy and cm_busy set, alloc_v/cm/dir stored, gnt[f]=1 for one cycle.
      - If none is free (blocked): no pulse, request stays pending.
    - In every case ptr=f+1 mod 5*NN and go IDLE.
- Latency:
  - gnt is visible 2 cycles after req is first sampled with an idle FSM and ptr on f.
  - At most one gnt or nack per 2 cycles.
- Requesters deassert req in the cycle after gnt or nack.
  - A req left high while alloc_v is set is ignored.
- Release:
  - rel[f] with alloc_v[f] clears imcfg, the CM cfg bit, im_busy, cm_busy and alloc_v on the next edge. Releases are processed every cycle, for any number of requesters in parallel.
  - rel[f] without alloc_v[f] is ignored.
- Release during SRCH: the search uses pre-release occupancy; freed resources are visible from the next cycle.
- Invariants:
  - Each CM output has at most one cfg bit set.
  - Each im_busy[p][m] maps to exactly one imcfg bit [p][m][*].

Optional Feature:
- CLOS_ALLOC_STAT_EN defined:
  - Adds output blk_cnt, 16 bits, counting SRCH cycles that end blocked.
  - Saturates at 16'hFFFF; cleared by reset.
  - Adds output blk, a 1-cycle pulse on each blocked search.
- CLOS_ALLOC_STAT_EN undefined: neither port exists; no counter logic.

Test Plan:
- Reset, then req[S][0] with dir=N (MN=2, NN=2):
  - gnt[0] pulses on cycle 2; imcfg[0][0][0]=1; ncfg[0]=2'b01.
  - All other configuration bits remain 0.
- Requests W0→S and E1→W:
  - W0 gets nack[2] and no configuration change.
  - E1 is granted with wcfg[0][2]=1.
- Requests L0→E, L1→E, then S0→E:
  - L0 gets CM0 and L1 gets CM1.
  - S0 is blocked with no gnt; blk_cnt increments each retry.
  - rel of L0: S0 is then granted on CM0 with ecfg[0]=4'b0001.
- All 10 requesters pending with legal distinct-conflict-free destinations:
  - Grants arrive in round-robin order from ptr=0, one per 2 cycles.
- rel in the same cycle as a SRCH that needs the released resource:
  - That search is blocked.
  - The retry on the next round-robin pass is granted.
- rst_n low during SRCH with an allocation in place:
  - No gnt.
  - All configuration outputs read 0 on the next cycle.
